// File: rtl/riscv_fetch_unit.sv
// Instruction fetch stage: owns the PC and issues credit-limited word reads to instruction memory.
// It also buffers returned words in a prefetch FIFO and flushes buffered and in-flight fetches on redirect.
module riscv_fetch_unit #(
    parameter int                ADDR_W     = 12,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              fetch_err
);
    localparam int          PW    = $clog2(FIFO_DEPTH);
    localparam int          CW    = PW + 1;
    localparam logic [CW:0] LIMIT = (CW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_ERR} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] r_fifo_pc   [FIFO_DEPTH];
    logic [31:0]       r_fifo_data [FIFO_DEPTH];
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;
    logic [ADDR_W-1:0] r_pcq [FIFO_DEPTH];
    logic [PW-1:0]     r_pcq_wptr;
    logic [PW-1:0]     r_pcq_rptr;
    logic [CW-1:0]     r_outstanding;
    logic [CW-1:0]     r_discard;

    logic w_misaligned;
    logic w_issue;
    logic w_resp;
    logic w_push;
    logic w_pop;

    assign w_misaligned = (redirect_pc[1:0] != 2'b00);
    // Outstanding requests hold a FIFO slot in reserve, so the FIFO can never overflow.
    assign w_issue = (r_state == S_RUN) && !redirect_valid &&
                     (({1'b0, r_count} + {1'b0, r_outstanding}) < LIMIT);
    assign w_resp  = imem_rvalid && (r_outstanding != '0);
    assign w_push  = w_resp && (r_discard == '0) && !redirect_valid;
    assign w_pop   = inst_valid && inst_ready && !redirect_valid;

    assign imem_req   = w_issue;
    assign imem_addr  = r_fetch_pc;
    assign inst_valid = (r_count != '0);
    assign inst_data  = r_fifo_data[r_rptr];
    assign inst_pc    = r_fifo_pc[r_rptr];
    assign fetch_err  = (r_state == S_ERR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (redirect_valid) begin
            w_state_nxt = w_misaligned ? S_ERR : S_RUN;
        end else if (r_state == S_IDLE) begin
            w_state_nxt = S_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc    <= RESET_PC;
            r_pcq_wptr    <= '0;
            r_pcq_rptr    <= '0;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            if (redirect_valid) begin
                r_fetch_pc <= redirect_pc;
            end else if (w_issue) begin
                r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
            end
            if (w_issue) begin
                r_pcq_wptr <= r_pcq_wptr + PW'(1);
            end
            if (w_resp) begin
                r_pcq_rptr <= r_pcq_rptr + PW'(1);
            end
            r_outstanding <= r_outstanding + CW'(w_issue) - CW'(w_resp);
            // Every request still in flight after a redirect belongs to the old stream.
            if (redirect_valid) begin
                r_discard <= r_outstanding - CW'(w_resp);
            end else if (w_resp && (r_discard != '0)) begin
                r_discard <= r_discard - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_issue) begin
            r_pcq[r_pcq_wptr] <= r_fetch_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_pc[i]   <= '0;
                r_fifo_data[i] <= '0;
            end
        end else if (redirect_valid) begin
            r_wptr  <= r_rptr;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_fifo_pc[r_wptr]   <= r_pcq[r_pcq_rptr];
                r_fifo_data[r_wptr] <= imem_rdata;
                r_wptr              <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    a_rvalid_expected: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rvalid |-> (r_outstanding != '0));

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Bench for riscv_fetch_unit: variable-latency memory model, instruction/address scoreboards and directed checks.
module tb_riscv_fetch_unit;
    typedef struct {
        int          due;
        logic [11:0] addr;
    } req_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [11:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        inst_valid;
    logic        inst_ready = 1'b1;
    logic [31:0] inst_data;
    logic [11:0] inst_pc;
    logic        redirect_valid = 1'b0;
    logic [11:0] redirect_pc = 12'h000;
    logic        fetch_err;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          lat = 1;
    int          nvalid;
    int          nreq;
    int          found;
    logic [11:0] exp_q[$];
    logic [11:0] exp_addr[$];
    req_t        pend[$];

    riscv_fetch_unit #(
        .ADDR_W(12),
        .FIFO_DEPTH(4),
        .RESET_PC(12'h000)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .inst_valid(inst_valid),
        .inst_ready(inst_ready),
        .inst_data(inst_data),
        .inst_pc(inst_pc),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .fetch_err(fetch_err)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [11:0] a);
        return {20'hC0DE0, a};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
        end
    endtask

    task automatic push_seq(input logic [11:0] start, input int n);
        logic [11:0] p;
        p = start;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(p);
            p = p + 12'd4;
        end
    endtask

    // Memory: responses in request order, each no earlier than lat cycles after its request.
    initial forever begin
        @(posedge clk);
        #1;
        cyc++;
        if (rst_n && pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = word(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            imem_rvalid = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n && imem_req) begin
            pend.push_back('{due: cyc + lat, addr: imem_addr});
        end
    end

    // Instruction monitor: every accepted instruction must be the next expected one.
    always @(negedge clk) begin
        if (rst_n && inst_valid && inst_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_inst: got pc 0x%03h, expected no instruction", inst_pc);
            end else begin
                logic [11:0] p;
                p = exp_q.pop_front();
                check("inst_pc", inst_pc, p);
                check("inst_data", inst_data, word(p));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && imem_req && exp_addr.size() > 0) begin
            logic [11:0] a;
            a = exp_addr.pop_front();
            check("imem_addr_seq", imem_addr, a);
        end
    end

    task automatic do_reset(input logic ready_val);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        pend.delete();
        exp_q.delete();
        exp_addr.delete();
        imem_rvalid = 1'b0;
        #1;
        check("rst_imem_req", imem_req, 0);
        check("rst_imem_addr", imem_addr, 0);
        check("rst_inst_valid", inst_valid, 0);
        check("rst_inst_data", inst_data, 0);
        check("rst_inst_pc", inst_pc, 0);
        check("rst_fetch_err", fetch_err, 0);
        inst_ready = ready_val;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset release with 1-cycle memory and ready=1
        do_reset(1'b1);
        push_seq(12'h000, 64);
        @(negedge clk);
        check("c1_imem_req", imem_req, 1);
        check("c1_imem_addr", imem_addr, 12'h000);
        check("c1_inst_valid", inst_valid, 0);
        @(negedge clk);
        check("c2_inst_valid", inst_valid, 0);
        @(negedge clk);
        check("c3_inst_valid", inst_valid, 1);
        check("c3_inst_pc", inst_pc, 12'h000);
        nvalid = 1;
        repeat (15) begin
            @(negedge clk);
            if (inst_valid) nvalid++;
        end
        check("stream_no_gaps", nvalid, 16);

        @(posedge clk);
        #2;
        inst_ready = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("full_imem_req", imem_req, 0);
        check("full_inst_valid", inst_valid, 1);

        // Reset mid-stream with the FIFO full, then restart stalled
        do_reset(1'b0);
        push_seq(12'h000, 64);
        exp_addr.push_back(12'h000);
        exp_addr.push_back(12'h004);
        exp_addr.push_back(12'h008);
        exp_addr.push_back(12'h00C);
        nreq = 0;
        repeat (10) begin
            @(negedge clk);
            if (imem_req) nreq++;
        end
        check("stall_req_count", nreq, 4);
        check("stall_req_idle", imem_req, 0);
        @(posedge clk);
        #2;
        inst_ready = 1'b1;
        repeat (12) @(posedge clk);

        // 3-cycle memory: redirect to 0x100 with 3 requests in flight
        #2;
        lat = 3;
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            @(posedge clk);
            #2;
            if (pend.size() == 2 && imem_rvalid) found = 1;
        end
        check("inflight3_found", found, 1);
        redirect_valid = 1'b1;
        redirect_pc = 12'h100;
        exp_q.delete();
        push_seq(12'h100, 64);
        @(negedge clk);
        check("redir_no_req", imem_req, 0);
        @(posedge clk);
        #2;
        redirect_valid = 1'b0;
        @(negedge clk);
        check("redir_req", imem_req, 1);
        check("redir_addr", imem_addr, 12'h100);
        check("redir_n1_valid", inst_valid, 0);
        repeat (3) @(negedge clk);
        check("redir_n4_valid", inst_valid, 0);
        @(negedge clk);
        check("redir_n5_valid", inst_valid, 1);
        check("redir_n5_pc", inst_pc, 12'h100);
        repeat (10) @(posedge clk);

        // Drain, then redirect near the top of memory to see the address wrap
        #2;
        inst_ready = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        lat = 1;
        inst_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 12'hFF8;
        exp_q.delete();
        push_seq(12'hFF8, 64);
        exp_addr.push_back(12'hFF8);
        exp_addr.push_back(12'hFFC);
        exp_addr.push_back(12'h000);
        exp_addr.push_back(12'h004);
        @(negedge clk);
        @(posedge clk);
        #2;
        redirect_valid = 1'b0;
        @(negedge clk);
        check("wrap_n1_req", imem_req, 1);
        @(negedge clk);
        check("wrap_n2_valid", inst_valid, 0);
        @(negedge clk);
        check("wrap_n3_valid", inst_valid, 1);
        check("wrap_n3_pc", inst_pc, 12'hFF8);
        check("wrap_n3_data", inst_data, word(12'hFF8));
        repeat (10) @(posedge clk);

        // Misaligned redirect halts fetch until an aligned one arrives
        #2;
        redirect_valid = 1'b1;
        redirect_pc = 12'h102;
        exp_q.delete();
        @(negedge clk);
        check("err_same_cycle", fetch_err, 0);
        @(posedge clk);
        #2;
        redirect_valid = 1'b0;
        @(negedge clk);
        check("err_set", fetch_err, 1);
        check("err_no_req", imem_req, 0);
        check("err_no_valid", inst_valid, 0);
        repeat (4) @(negedge clk);
        check("err_hold", fetch_err, 1);
        check("err_hold_no_req", imem_req, 0);
        check("err_hold_no_valid", inst_valid, 0);
        @(posedge clk);
        #2;
        redirect_valid = 1'b1;
        redirect_pc = 12'h040;
        push_seq(12'h040, 64);
        exp_addr.push_back(12'h040);
        exp_addr.push_back(12'h044);
        @(negedge clk);
        check("err_recover_cycle", fetch_err, 1);
        @(posedge clk);
        #2;
        redirect_valid = 1'b0;
        @(negedge clk);
        check("err_cleared", fetch_err, 0);
        check("err_resume_req", imem_req, 1);
        repeat (2) @(negedge clk);
        check("err_resume_valid", inst_valid, 1);
        check("err_resume_pc", inst_pc, 12'h040);
        repeat (8) @(posedge clk);
        #2;
        inst_ready = 1'b0;
        repeat (4) @(posedge clk);
        check("addr_seq_drained", exp_addr.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
